// File: rtl/cpu_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_defs_pkg
// Description : Opcodes, FSM state encoding and IR field layout shared by the
//               ALU control sequencer and its instruction field decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_defs_pkg;

  localparam logic [4:0] c_op_add  = 5'b00011;
  localparam logic [4:0] c_op_sub  = 5'b00100;
  localparam logic [4:0] c_op_and  = 5'b00101;
  localparam logic [4:0] c_op_or   = 5'b00110;
  localparam logic [4:0] c_op_shr  = 5'b00111;
  localparam logic [4:0] c_op_shl  = 5'b01000;
  localparam logic [4:0] c_op_ror  = 5'b01001;
  localparam logic [4:0] c_op_rol  = 5'b01010;
  localparam logic [4:0] c_op_mul  = 5'b01011;
  localparam logic [4:0] c_op_div  = 5'b01100;
  localparam logic [4:0] c_op_neg  = 5'b01101;
  localparam logic [4:0] c_op_not  = 5'b01110;
  localparam logic [4:0] c_op_halt = 5'b11111;

  localparam logic [3:0] c_s_idle = 4'd0;
  localparam logic [3:0] c_s_t0   = 4'd1;
  localparam logic [3:0] c_s_t1   = 4'd2;
  localparam logic [3:0] c_s_t2   = 4'd3;
  localparam logic [3:0] c_s_t3   = 4'd4;
  localparam logic [3:0] c_s_t4   = 4'd5;
  localparam logic [3:0] c_s_t5   = 4'd6;
  localparam logic [3:0] c_s_t6   = 4'd7;
  localparam logic [3:0] c_s_done = 4'd8;
  localparam logic [3:0] c_s_halt = 4'd9;

  localparam int c_ir_op_lsb = 27;
  localparam int c_ir_ra_lsb = 23;
  localparam int c_ir_rb_lsb = 19;
  localparam int c_ir_rc_lsb = 15;

  typedef struct packed {
    logic is_binary;
    logic is_unary;
    logic is_muldiv;
    logic is_halt;
    logic is_legal;
  } op_class_t;

  function automatic op_class_t classify_op(input logic [4:0] op);
    op_class_t cls;
    cls           = '0;
    cls.is_binary = (op >= c_op_add) && (op <= c_op_div);
    cls.is_unary  = (op == c_op_neg) || (op == c_op_not);
    cls.is_muldiv = (op == c_op_mul) || (op == c_op_div);
    cls.is_halt   = (op == c_op_halt);
    cls.is_legal  = cls.is_binary || cls.is_unary || cls.is_halt;
    return cls;
  endfunction

endpackage : cpu_defs_pkg
`default_nettype wire

// File: rtl/ir_field_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ir_field_decoder
// Description : Splits the instruction word into opcode and one-hot register
//               selects, and classifies the opcode.
// Revision    : 1.0 - initial release
// ============================================================================
module ir_field_decoder
  import cpu_defs_pkg::*;
(
  input  logic [31:0] ir,
  output logic [4:0]  opcode,
  output logic [15:0] ra_onehot,
  output logic [15:0] rb_onehot,
  output logic [15:0] rc_onehot,
  output logic        is_binary,
  output logic        is_unary,
  output logic        is_muldiv,
  output logic        is_halt,
  output logic        is_legal
);

  logic [3:0] w_ra;
  logic [3:0] w_rb;
  logic [3:0] w_rc;
  op_class_t  w_cls;
  logic       w_ir_unused;

  assign opcode = ir[c_ir_op_lsb +: 5];
  assign w_ra   = ir[c_ir_ra_lsb +: 4];
  assign w_rb   = ir[c_ir_rb_lsb +: 4];
  assign w_rc   = ir[c_ir_rc_lsb +: 4];

  // Low IR bits hold immediates that register-register ops never look at.
  assign w_ir_unused = ^ir[c_ir_rc_lsb-1:0];

  generate
    for (genvar i = 0; i < 16; i++) begin : g_onehot
      assign ra_onehot[i] = (w_ra == 4'(i));
      assign rb_onehot[i] = (w_rb == 4'(i));
      assign rc_onehot[i] = (w_rc == 4'(i));
    end
  endgenerate

  assign w_cls     = classify_op(opcode);
  assign is_binary = w_cls.is_binary;
  assign is_unary  = w_cls.is_unary;
  assign is_muldiv = w_cls.is_muldiv;
  assign is_halt   = w_cls.is_halt;
  assign is_legal  = w_cls.is_legal;

endmodule : ir_field_decoder
`default_nettype wire

// File: rtl/alu_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_control_sequencer
// Description : Moore FSM driving fetch (T0-T2) and register-register ALU
//               execution (T3-T6) controls for the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_control_sequencer
  import cpu_defs_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] IR_Data,
  output logic        PC_select,
  output logic        PC_enable,
  output logic        PC_increment_enable,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        MDR_select,
  output logic        read,
  output logic        IR_enable,
  output logic        Y_enable,
  output logic        Z_enable,
  output logic        Z_HI_select,
  output logic        Z_LO_select,
  output logic        HI_enable,
  output logic        LO_enable,
  output logic [15:0] reg_select,
  output logic [15:0] reg_enable,
  output logic [4:0]  alu_instruction,
  output logic        done,
  output logic        halted
);

  localparam int c_cnt_w = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);

  logic [3:0]         r_state;
  logic [3:0]         w_state_next;
  logic [c_cnt_w-1:0] r_wait_cnt;
  logic [c_cnt_w-1:0] w_wait_cnt_inc;
  logic [c_cnt_w-1:0] w_wait_cnt_d;

  logic [4:0]  w_opcode;
  logic [15:0] w_ra_oh;
  logic [15:0] w_rb_oh;
  logic [15:0] w_rc_oh;
  logic        w_is_binary;
  logic        w_is_unary;
  logic        w_is_muldiv;
  logic        w_is_halt;
  logic        w_is_legal;

  ir_field_decoder u_ir_field_decoder (
    .ir        (IR_Data),
    .opcode    (w_opcode),
    .ra_onehot (w_ra_oh),
    .rb_onehot (w_rb_oh),
    .rc_onehot (w_rc_oh),
    .is_binary (w_is_binary),
    .is_unary  (w_is_unary),
    .is_muldiv (w_is_muldiv),
    .is_halt   (w_is_halt),
    .is_legal  (w_is_legal)
  );

  assign w_wait_cnt_inc = r_wait_cnt + c_cnt_w'(1);

  // Counter is zero on the first T1 cycle and only advances on wait cycles.
  always_comb begin
    w_wait_cnt_d = '0;
    if (r_state == c_s_t1 && !mem_ready) begin
      w_wait_cnt_d = w_wait_cnt_inc;
    end else if (r_state == c_s_t1) begin
      w_wait_cnt_d = r_wait_cnt;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_s_idle: if (run) w_state_next = c_s_t0;
      c_s_t0:   w_state_next = c_s_t1;
      c_s_t1: begin
        if (mem_ready) begin
          w_state_next = c_s_t2;
        end else if (w_wait_cnt_inc == c_cnt_w'(MEM_WAIT_MAX)) begin
          w_state_next = c_s_halt;
        end
      end
      // Decided on the edge that closes T2, i.e. the IR value that T3 onward uses.
      c_s_t2: begin
        if (!w_is_legal)      w_state_next = c_s_done;
        else if (w_is_halt)   w_state_next = c_s_halt;
        else if (w_is_binary) w_state_next = c_s_t3;
        else                  w_state_next = c_s_t4;
      end
      c_s_t3:   w_state_next = c_s_t4;
      c_s_t4:   w_state_next = c_s_t5;
      c_s_t5:   w_state_next = w_is_muldiv ? c_s_t6 : c_s_done;
      c_s_t6:   w_state_next = c_s_done;
      c_s_done: w_state_next = run ? c_s_t0 : c_s_idle;
      c_s_halt: w_state_next = c_s_halt;
      default:  w_state_next = c_s_idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      r_state    <= c_s_idle;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_d;
    end
  end

  always_comb begin
    PC_select           = 1'b0;
    PC_enable           = 1'b0;
    PC_increment_enable = 1'b0;
    MAR_enable          = 1'b0;
    MDR_enable          = 1'b0;
    MDR_select          = 1'b0;
    read                = 1'b0;
    IR_enable           = 1'b0;
    Y_enable            = 1'b0;
    Z_enable            = 1'b0;
    Z_HI_select         = 1'b0;
    Z_LO_select         = 1'b0;
    HI_enable           = 1'b0;
    LO_enable           = 1'b0;
    reg_select          = 16'h0000;
    reg_enable          = 16'h0000;
    alu_instruction     = 5'b00000;
    done                = 1'b0;
    halted              = 1'b0;
    case (r_state)
      c_s_t0: begin
        PC_select           = 1'b1;
        MAR_enable          = 1'b1;
        PC_increment_enable = 1'b1;
        Z_enable            = 1'b1;
      end
      c_s_t1: begin
        Z_LO_select = 1'b1;
        PC_enable   = (r_wait_cnt == '0);
        read        = 1'b1;
        MDR_enable  = 1'b1;
      end
      c_s_t2: begin
        MDR_select = 1'b1;
        IR_enable  = 1'b1;
      end
      c_s_t3: begin
        reg_select = w_rb_oh;
        Y_enable   = 1'b1;
      end
      c_s_t4: begin
        reg_select      = w_is_unary ? w_rb_oh : w_rc_oh;
        alu_instruction = w_opcode;
        Z_enable        = 1'b1;
      end
      c_s_t5: begin
        Z_LO_select = 1'b1;
        if (w_is_muldiv) LO_enable  = 1'b1;
        else             reg_enable = w_ra_oh;
      end
      c_s_t6: begin
        Z_HI_select = 1'b1;
        HI_enable   = 1'b1;
      end
      c_s_done: done   = 1'b1;
      c_s_halt: halted = 1'b1;
      default: ;
    endcase
  end

endmodule : alu_control_sequencer
`default_nettype wire

// File: tb/tb_alu_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_control_sequencer
// Description : Scoreboard bench; stimulus queues per-cycle expected control
//               vectors, a negedge monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_control_sequencer;

  logic        clk = 1'b0;
  logic        clear;
  logic        run;
  logic        mem_ready;
  logic [31:0] IR_Data;
  logic        PC_select, PC_enable, PC_increment_enable, MAR_enable;
  logic        MDR_enable, MDR_select, read, IR_enable, Y_enable, Z_enable;
  logic        Z_HI_select, Z_LO_select, HI_enable, LO_enable, done, halted;
  logic [15:0] reg_select;
  logic [15:0] reg_enable;
  logic [4:0]  alu_instruction;

  alu_control_sequencer #(.MEM_WAIT_MAX(15)) dut (
    .clk                 (clk),
    .clear               (clear),
    .run                 (run),
    .mem_ready           (mem_ready),
    .IR_Data             (IR_Data),
    .PC_select           (PC_select),
    .PC_enable           (PC_enable),
    .PC_increment_enable (PC_increment_enable),
    .MAR_enable          (MAR_enable),
    .MDR_enable          (MDR_enable),
    .MDR_select          (MDR_select),
    .read                (read),
    .IR_enable           (IR_enable),
    .Y_enable            (Y_enable),
    .Z_enable            (Z_enable),
    .Z_HI_select         (Z_HI_select),
    .Z_LO_select         (Z_LO_select),
    .HI_enable           (HI_enable),
    .LO_enable           (LO_enable),
    .reg_select          (reg_select),
    .reg_enable          (reg_enable),
    .alu_instruction     (alu_instruction),
    .done                (done),
    .halted              (halted)
  );

  always #5 clk = ~clk;

  // Flag word: [15] PC_select [14] PC_enable [13] PC_increment_enable
  // [12] MAR_enable [11] MDR_enable [10] MDR_select [9] read [8] IR_enable
  // [7] Y_enable [6] Z_enable [5] Z_HI_select [4] Z_LO_select [3] HI_enable
  // [2] LO_enable [1] done [0] halted
  localparam logic [15:0] c_f_t0   = 16'hB040;
  localparam logic [15:0] c_f_t1a  = 16'h4A10;
  localparam logic [15:0] c_f_t1   = 16'h0A10;
  localparam logic [15:0] c_f_t2   = 16'h0500;
  localparam logic [15:0] c_f_t3   = 16'h0080;
  localparam logic [15:0] c_f_t4   = 16'h0040;
  localparam logic [15:0] c_f_t5   = 16'h0010;
  localparam logic [15:0] c_f_t5md = 16'h0014;
  localparam logic [15:0] c_f_t6   = 16'h0028;
  localparam logic [15:0] c_f_done = 16'h0002;
  localparam logic [15:0] c_f_halt = 16'h0001;

  localparam int c_k_bin   = 0;
  localparam int c_k_un    = 1;
  localparam int c_k_md    = 2;
  localparam int c_k_undef = 3;

  typedef struct {
    int          cyc;
    string       name;
    logic [52:0] vec;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        r_mon;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [52:0] w_dut;

  assign w_dut = {PC_select, PC_enable, PC_increment_enable, MAR_enable,
                  MDR_enable, MDR_select, read, IR_enable, Y_enable, Z_enable,
                  Z_HI_select, Z_LO_select, HI_enable, LO_enable, done, halted,
                  reg_select, reg_enable, alu_instruction};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      r_mon = exp_q.pop_front();
      n_tests++;
      if (r_mon.cyc != cyc || w_dut !== r_mon.vec) begin
        n_fail++;
        $display("FAIL %s (cycle %0d, seen at %0d): got %h expected %h",
                 r_mon.name, r_mon.cyc, cyc, w_dut, r_mon.vec);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [52:0] pack(input logic [15:0] f, input logic [15:0] rs,
                                       input logic [15:0] re, input logic [4:0] alu);
    return {f, rs, re, alu};
  endfunction

  task automatic push(input int c, input string nm, input logic [52:0] v);
    exp_t e;
    e.cyc  = c;
    e.name = nm;
    e.vec  = v;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected trace of one instruction from T0 through its DONE cycle.
  task automatic expect_instr(input string tag, input int t0, input int waits,
                              input int kind, input logic [15:0] ra,
                              input logic [15:0] rb, input logic [15:0] rc,
                              input logic [4:0] op, output int done_cyc);
    int c;
    c = t0;
    push(c, {tag, "_T0"}, pack(c_f_t0, 16'h0, 16'h0, 5'h0)); c++;
    push(c, {tag, "_T1first"}, pack(c_f_t1a, 16'h0, 16'h0, 5'h0)); c++;
    for (int i = 0; i < waits; i++) begin
      push(c, {tag, "_T1wait"}, pack(c_f_t1, 16'h0, 16'h0, 5'h0)); c++;
    end
    push(c, {tag, "_T2"}, pack(c_f_t2, 16'h0, 16'h0, 5'h0)); c++;
    if (kind == c_k_bin || kind == c_k_md) begin
      push(c, {tag, "_T3"}, pack(c_f_t3, rb, 16'h0, 5'h0)); c++;
    end
    if (kind != c_k_undef) begin
      push(c, {tag, "_T4"}, pack(c_f_t4, (kind == c_k_un) ? rb : rc, 16'h0, op)); c++;
      if (kind == c_k_md) begin
        push(c, {tag, "_T5"}, pack(c_f_t5md, 16'h0, 16'h0, 5'h0)); c++;
        push(c, {tag, "_T6"}, pack(c_f_t6, 16'h0, 16'h0, 5'h0)); c++;
      end else begin
        push(c, {tag, "_T5"}, pack(c_f_t5, 16'h0, ra, 5'h0)); c++;
      end
    end
    push(c, {tag, "_DONE"}, pack(c_f_done, 16'h0, 16'h0, 5'h0));
    done_cyc = c;
  endtask

  // Start from IDLE, run one instruction with `waits` mem_ready-low T1 cycles.
  task automatic run_simple(input string tag, input logic [31:0] ir, input int kind,
                            input logic [15:0] ra, input logic [15:0] rb,
                            input logic [15:0] rc, input logic [4:0] op,
                            input int waits, input int exp_latency);
    int c;
    int d;
    c         = cyc;
    IR_Data   = ir;
    mem_ready = (waits == 0);
    run       = 1'b1;
    expect_instr(tag, c + 1, waits, kind, ra, rb, rc, op, d);
    n_tests++;
    if (d - c != exp_latency) begin
      n_fail++;
      $display("FAIL %s_latency: trace length %0d required %0d", tag, d - c, exp_latency);
    end
    push(d + 1, {tag, "_IDLE"}, '0);
    wait_cyc(c + 1);
    run = 1'b0;
    if (waits > 0) begin
      wait_cyc(c + 2 + waits);
      mem_ready = 1'b1;
    end
    wait_cyc(d + 1);
  endtask

  initial begin
    int c;
    int d1;
    int d2;

    // Reset held two cycles with run asserted, then T0 on the release edge.
    clear     = 1'b1;
    run       = 1'b1;
    mem_ready = 1'b1;
    IR_Data   = 32'h389A8000;
    push(1, "reset_c1", '0);
    push(2, "reset_c2", '0);
    wait_cyc(2);
    clear = 1'b0;
    expect_instr("shr", 3, 0, c_k_bin, 16'h0002, 16'h0008, 16'h0020, 5'b00111, d1);
    push(d1 + 1, "shr_IDLE", '0);
    wait_cyc(8);
    run = 1'b0;
    wait_cyc(d1 + 1);

    // Three wait cycles in T1: 10 cycles T0 -> DONE.
    run_simple("shr_wait3", 32'h389A8000, c_k_bin, 16'h0002, 16'h0008, 16'h0020,
               5'b00111, 3, 10);

    // MUL R6 <- R2 * R4.
    run_simple("mul", 32'h5B120000, c_k_md, 16'h0040, 16'h0004, 16'h0010,
               5'b01011, 0, 8);

    // Undefined opcode 00000 goes straight to DONE after T2.
    run_simple("undef", 32'h00000000, c_k_undef, 16'h0, 16'h0, 16'h0, 5'b0, 0, 4);

    // NOT R7 <- ~R9, run kept high so DONE chains into a second T0.
    c         = cyc;
    IR_Data   = 32'h73C80000;
    mem_ready = 1'b1;
    run       = 1'b1;
    expect_instr("not1", c + 1, 0, c_k_un, 16'h0080, 16'h0200, 16'h0001, 5'b01110, d1);
    expect_instr("not2", d1 + 1, 0, c_k_un, 16'h0080, 16'h0200, 16'h0001, 5'b01110, d2);
    push(d2 + 1, "not_IDLE", '0);
    wait_cyc(d1 + 1);
    run = 1'b0;
    wait_cyc(d2 + 1);

    // HALT opcode: halted stays high while run toggles, cleared only by clear.
    c       = cyc;
    IR_Data = 32'hF8000000;
    run     = 1'b1;
    push(c + 1, "halt_T0", pack(c_f_t0, 16'h0, 16'h0, 5'h0));
    push(c + 2, "halt_T1", pack(c_f_t1a, 16'h0, 16'h0, 5'h0));
    push(c + 3, "halt_T2", pack(c_f_t2, 16'h0, 16'h0, 5'h0));
    for (int i = 4; i <= 8; i++) push(c + i, "halt_HALT", pack(c_f_halt, 16'h0, 16'h0, 5'h0));
    push(c + 9, "halt_clear_IDLE", '0);
    push(c + 10, "halt_after_IDLE", '0);
    wait_cyc(c + 1);
    run = 1'b0;
    wait_cyc(c + 5);
    run = 1'b1;
    wait_cyc(c + 7);
    run = 1'b0;
    wait_cyc(c + 8);
    clear = 1'b1;
    wait_cyc(c + 9);
    clear = 1'b0;
    wait_cyc(c + 10);

    // mem_ready never arrives: 15 T1 cycles, then HALT.
    c         = cyc;
    IR_Data   = 32'h389A8000;
    mem_ready = 1'b0;
    run       = 1'b1;
    push(c + 1, "tmo_T0", pack(c_f_t0, 16'h0, 16'h0, 5'h0));
    push(c + 2, "tmo_T1first", pack(c_f_t1a, 16'h0, 16'h0, 5'h0));
    for (int i = 3; i <= 16; i++) push(c + i, "tmo_T1wait", pack(c_f_t1, 16'h0, 16'h0, 5'h0));
    push(c + 17, "tmo_HALT", pack(c_f_halt, 16'h0, 16'h0, 5'h0));
    push(c + 18, "tmo_HALT2", pack(c_f_halt, 16'h0, 16'h0, 5'h0));
    push(c + 19, "tmo_clear_IDLE", '0);
    push(c + 20, "tmo_after_IDLE", '0);
    wait_cyc(c + 1);
    run = 1'b0;
    wait_cyc(c + 18);
    clear = 1'b1;
    wait_cyc(c + 19);
    clear     = 1'b0;
    mem_ready = 1'b1;
    wait_cyc(c + 20);

    // clear during T4 aborts: no write-back, no done.
    c         = cyc;
    IR_Data   = 32'h389A8000;
    mem_ready = 1'b1;
    run       = 1'b1;
    push(c + 1, "abort_T0", pack(c_f_t0, 16'h0, 16'h0, 5'h0));
    push(c + 2, "abort_T1", pack(c_f_t1a, 16'h0, 16'h0, 5'h0));
    push(c + 3, "abort_T2", pack(c_f_t2, 16'h0, 16'h0, 5'h0));
    push(c + 4, "abort_T3", pack(c_f_t3, 16'h0008, 16'h0, 5'h0));
    push(c + 5, "abort_T4", pack(c_f_t4, 16'h0020, 16'h0, 5'b00111));
    for (int i = 6; i <= 9; i++) push(c + i, "abort_IDLE", '0);
    wait_cyc(c + 1);
    run = 1'b0;
    wait_cyc(c + 5);
    clear = 1'b1;
    wait_cyc(c + 6);
    clear = 1'b0;
    wait_cyc(c + 10);

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_alu_control_sequencer
`default_nettype wire
